// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if
//   Bundles the requester-side handshake and the ALU-side bus of
//   alu_req_arbiter.
//   slave  : the arbiter's view (drives req_ready/resp_*/alu_*).
//   master : the environment's view (requesters plus the ALU instance).
// Signals
//   req_valid/req_ready   per-requester request handshake (NUM_REQ bits)
//   req_sr1/sr2/sext      packed operands, DATA_W bits per requester
//   req_aluk              packed ALUK, 2 bits per requester (00 ADD, 01 AND, 10 NOT, 11 PASSA)
//   req_sr2mux            per-requester operand-B select (1 = sext)
//   resp_valid/resp_ack   per-requester response handshake, resp_data shared
//   alu_sr1/sr2/sext/aluk/sr2mux  ALU inputs, alu_result registered ALU output
interface alu_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_sr1;
  logic [NUM_REQ*DATA_W-1:0] req_sr2;
  logic [NUM_REQ*DATA_W-1:0] req_sext;
  logic [NUM_REQ*2-1:0]      req_aluk;
  logic [NUM_REQ-1:0]        req_sr2mux;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic [NUM_REQ-1:0]        resp_ack;
  logic [DATA_W-1:0]         alu_sr1;
  logic [DATA_W-1:0]         alu_sr2;
  logic [DATA_W-1:0]         alu_sext;
  logic [1:0]                alu_aluk;
  logic                      alu_sr2mux;
  logic [DATA_W-1:0]         alu_result;

  modport slave (
    input  req_valid, req_sr1, req_sr2, req_sext, req_aluk, req_sr2mux,
    input  resp_ack, alu_result,
    output req_ready, resp_valid, resp_data,
    output alu_sr1, alu_sr2, alu_sext, alu_aluk, alu_sr2mux
  );

  modport master (
    output req_valid, req_sr1, req_sr2, req_sext, req_aluk, req_sr2mux,
    output resp_ack, alu_result,
    input  req_ready, resp_valid, resp_data,
    input  alu_sr1, alu_sr2, alu_sext, alu_aluk, alu_sr2mux
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one LC-3 ALU (one-cycle registered result) between NUM_REQ
//   requesters. One operation in flight: IDLE -> ISSUE -> WAIT -> RESP,
//   PASSA skips WAIT and returns the latched sr1 directly.
// Ports
//   Clk       system clock (posedge)
//   Reset_al  asynchronous active-low reset
//   bus       alu_req_arbiter_if.slave: request/response handshakes + ALU bus
//   busy      high whenever the FSM is not IDLE
// Configuration
//   ALU_ARB_ROUND_ROBIN_EN defined  : round-robin from the rr pointer.
//   ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins.
module alu_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_al,
  alu_req_arbiter_if.slave  bus,
  output logic              busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [DATA_W-1:0]   sr1_q, sr1_d;
  logic [DATA_W-1:0]   sr2_q, sr2_d;
  logic [DATA_W-1:0]   sext_q, sext_d;
  logic [1:0]          aluk_q, aluk_d;
  logic                sr2mux_q, sr2mux_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

  logic                any_valid;
  logic [GW-1:0]       win;
  logic [DATA_W-1:0]   sel_sr1, sel_sr2, sel_sext;
  logic [1:0]          sel_aluk;
  logic                sel_sr2mux;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW:0]         rr_sum;

  // Search starts at rr_q and wraps modulo NUM_REQ; the extra sum bit keeps
  // the wrap correct for non-power-of-two NUM_REQ.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    rr_sum    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, rr_q} + (GW+1)'(i);
      if (rr_sum >= (GW+1)'(NUM_REQ)) rr_sum = rr_sum - (GW+1)'(NUM_REQ);
      if (!any_valid && bus.req_valid[rr_sum[GW-1:0]]) begin
        any_valid = 1'b1;
        win       = rr_sum[GW-1:0];
      end
    end
  end
`else
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && bus.req_valid[i]) begin
        any_valid = 1'b1;
        win       = GW'(i);
      end
    end
  end
`endif

  // Operand fields of the winning requester.
  always_comb begin
    sel_sr1    = '0;
    sel_sr2    = '0;
    sel_sext   = '0;
    sel_aluk   = '0;
    sel_sr2mux = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == GW'(i)) begin
        sel_sr1    = bus.req_sr1[i*DATA_W +: DATA_W];
        sel_sr2    = bus.req_sr2[i*DATA_W +: DATA_W];
        sel_sext   = bus.req_sext[i*DATA_W +: DATA_W];
        sel_aluk   = bus.req_aluk[i*2 +: 2];
        sel_sr2mux = bus.req_sr2mux[i];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    sr1_d          = sr1_q;
    sr2_d          = sr2_q;
    sext_d         = sext_q;
    aluk_d         = aluk_q;
    sr2mux_d       = sr2mux_q;
    resp_data_d    = resp_data_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    rr_d           = rr_q;
`endif
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = (win == GW'(i));
          end
          gnt_d    = win;
          sr1_d    = sel_sr1;
          sr2_d    = sel_sr2;
          sext_d   = sel_sext;
          aluk_d   = sel_aluk;
          sr2mux_d = sel_sr2mux;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          rr_d     = (win == GW'(NUM_REQ-1)) ? '0 : win + 1'b1;
`endif
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // PASSA needs no ALU round trip: return sr1 one cycle early.
        if (aluk_q == 2'b11) begin
          resp_data_d = sr1_q;
          state_d     = RESP;
        end else begin
          state_d     = WAIT;
        end
      end
      WAIT: begin
        resp_data_d = bus.alu_result;
        state_d     = RESP;
      end
      RESP: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          bus.resp_valid[i] = (gnt_q == GW'(i));
        end
        if (bus.resp_ack[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sr1_q       <= '0;
      sr2_q       <= '0;
      sext_q      <= '0;
      aluk_q      <= '0;
      sr2mux_q    <= 1'b0;
      resp_data_q <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sr1_q       <= sr1_d;
      sr2_q       <= sr2_d;
      sext_q      <= sext_d;
      aluk_q      <= aluk_d;
      sr2mux_q    <= sr2mux_d;
      resp_data_q <= resp_data_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // Operand latches drive the ALU directly, so its inputs are registered
  // and hold steady from ISSUE through WAIT.
  assign bus.alu_sr1    = sr1_q;
  assign bus.alu_sr2    = sr2_q;
  assign bus.alu_sext   = sext_q;
  assign bus.alu_aluk   = aluk_q;
  assign bus.alu_sr2mux = sr2mux_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

  logic Clk;
  logic Reset_al;
  logic busy;
  int   checks;
  int   errors;

  alu_req_arbiter_if #(.NUM_REQ(2), .DATA_W(16)) bus ();

  alu_req_arbiter #(.NUM_REQ(2), .DATA_W(16)) dut (
    .Clk      (Clk),
    .Reset_al (Reset_al),
    .bus      (bus),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered LC-3 ALU. PASSA yields a marker value instead of sr1 so a
  // design that wrongly routes the ALU result for PASSA is exposed.
  logic [15:0] alu_b;
  assign alu_b = bus.alu_sr2mux ? bus.alu_sext : bus.alu_sr2;
  always @(posedge Clk) begin
    case (bus.alu_aluk)
      2'b00:   bus.alu_result <= bus.alu_sr1 + alu_b;
      2'b01:   bus.alu_result <= bus.alu_sr1 & alu_b;
      2'b10:   bus.alu_result <= ~bus.alu_sr1;
      default: bus.alu_result <= 16'hDEAD;
    endcase
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [1:0] aluk, input logic [15:0] sr1,
                         input logic [15:0] sr2, input logic [15:0] sext, input logic mux);
    bus.req_sr1[idx*16 +: 16]  = sr1;
    bus.req_sr2[idx*16 +: 16]  = sr2;
    bus.req_sext[idx*16 +: 16] = sext;
    bus.req_aluk[idx*2 +: 2]   = aluk;
    bus.req_sr2mux[idx]        = mux;
    bus.req_valid[idx]         = 1'b1;
  endtask

  task automatic do_reset();
    Reset_al = 1'b0;
    tick();
    tick();
    Reset_al = 1'b1;
    tick();
  endtask

  // Power-up values, then an asynchronous reset while a result is pending.
  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b exp 00", bus.resp_valid); end
    checks++; if (bus.alu_sr1 !== 16'h0 || bus.alu_aluk !== 2'b00 || bus.resp_data !== 16'h0)
      begin errors++; $display("FAIL rst_regs got sr1=%h aluk=%b data=%h exp 0", bus.alu_sr1, bus.alu_aluk, bus.resp_data); end
    set_req(0, 2'b00, 16'h1111, 16'h2222, 16'h0, 1'b0);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    checks++; if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL rst_pre_resp got %b exp 01", bus.resp_valid); end
    #2 Reset_al = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 2'b00 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_async got resp_valid=%b busy=%b exp 00/0", bus.resp_valid, busy); end
    checks++; if (bus.alu_sr1 !== 16'h0 || bus.alu_sr2 !== 16'h0 || bus.resp_data !== 16'h0)
      begin errors++; $display("FAIL rst_async_regs got sr1=%h sr2=%h data=%h exp 0", bus.alu_sr1, bus.alu_sr2, bus.resp_data); end
    tick();
    Reset_al = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.resp_valid !== 2'b00 || busy !== 1'b0)
        begin errors++; $display("FAIL rst_no_resp c%0d got resp_valid=%b busy=%b exp 00/0", c, bus.resp_valid, busy); end
    end
  endtask

  typedef struct {
    int          idx;
    logic [1:0]  aluk;
    logic [15:0] sr1, sr2, sext;
    logic        mux;
    logic [15:0] exp;
  } op_t;

  // ADD/AND/NOT through the ALU with 3-cycle latency.
  task automatic test_alu_ops();
    op_t ops[4];
    logic [1:0] onehot;
    ops[0] = '{0, 2'b00, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 16'h8000};
    ops[1] = '{1, 2'b01, 16'hF0F0, 16'h1111, 16'h00FF, 1'b1, 16'h00F0};
    ops[2] = '{0, 2'b10, 16'h1234, 16'hFFFF, 16'h0000, 1'b0, 16'hEDCB};
    ops[3] = '{1, 2'b00, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 16'h0001};
    foreach (ops[k]) begin
      onehot = 2'b01 << ops[k].idx;
      set_req(ops[k].idx, ops[k].aluk, ops[k].sr1, ops[k].sr2, ops[k].sext, ops[k].mux);
      #1;
      checks++; if (bus.req_ready !== onehot) begin errors++; $display("FAIL op%0d_ready got %b exp %b", k, bus.req_ready, onehot); end
      tick();
      bus.req_valid = '0;
      checks++; if (busy !== 1'b1 || bus.alu_sr1 !== ops[k].sr1 || bus.alu_aluk !== ops[k].aluk || bus.alu_sr2mux !== ops[k].mux)
        begin errors++; $display("FAIL op%0d_issue got busy=%b sr1=%h aluk=%b mux=%b exp 1/%h/%b/%b", k, busy,
          bus.alu_sr1, bus.alu_aluk, bus.alu_sr2mux, ops[k].sr1, ops[k].aluk, ops[k].mux); end
      tick();
      checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL op%0d_early got %b exp 00", k, bus.resp_valid); end
      tick();
      checks++; if (bus.resp_valid !== onehot || bus.resp_data !== ops[k].exp)
        begin errors++; $display("FAIL op%0d_resp got valid=%b data=%h exp %b/%h", k, bus.resp_valid, bus.resp_data, onehot, ops[k].exp); end
      bus.resp_ack = onehot;
      tick();
      bus.resp_ack = '0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op%0d_idle got busy=%b exp 0", k, busy); end
    end
  endtask

  // PASSA returns sr1 two cycles after accept, bypassing the ALU result.
  task automatic test_passa();
    set_req(0, 2'b11, 16'hBEEF, 16'h0101, 16'h0000, 1'b0);
    tick();
    bus.req_valid = '0;
    checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL passa_c1 got %b exp 00", bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 16'hBEEF)
      begin errors++; $display("FAIL passa_resp got valid=%b data=%h exp 01/beef", bus.resp_valid, bus.resp_data); end
    bus.resp_ack = 2'b01;
    tick();
    bus.resp_ack = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL passa_idle got busy=%b exp 0", busy); end
  endtask

  // Both requesters valid continuously; ack (on all bits) as soon as valid.
  task automatic test_arbitration();
    logic [1:0] exp_g[4];
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    set_req(0, 2'b00, 16'h0001, 16'h0002, 16'h0, 1'b0);
    set_req(1, 2'b00, 16'h0010, 16'h0020, 16'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.req_ready !== exp_g[k]) begin errors++; $display("FAIL arb%0d_ready got %b exp %b", k, bus.req_ready, exp_g[k]); end
      tick();
      tick();
      tick();
      checks++; if (bus.resp_valid !== exp_g[k] || bus.resp_data !== ((exp_g[k] == 2'b01) ? 16'h0003 : 16'h0030))
        begin errors++; $display("FAIL arb%0d_resp got valid=%b data=%h exp %b", k, bus.resp_valid, bus.resp_data, exp_g[k]); end
      bus.resp_ack = 2'b11;
      tick();
      bus.resp_ack = '0;
    end
    bus.req_valid = '0;
  endtask

  // Result held while ack is withheld; waiting req1 only granted after ack.
  task automatic test_ack_hold();
    do_reset();
    set_req(0, 2'b00, 16'h0005, 16'h0006, 16'h0, 1'b0);
    tick();
    bus.req_valid[0] = 1'b0;
    set_req(1, 2'b01, 16'h0F0F, 16'h00FF, 16'hFFFF, 1'b0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 16'h000B || bus.req_ready !== 2'b00)
        begin errors++; $display("FAIL hold_c%0d got valid=%b data=%h ready=%b exp 01/000b/00", c,
          bus.resp_valid, bus.resp_data, bus.req_ready); end
      tick();
    end
    bus.resp_ack = 2'b10;
    #1;
    checks++; if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL hold_wrong_ack got %b exp 01", bus.resp_valid); end
    tick();
    bus.resp_ack = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL hold_ack_cycle_ready got %b exp 00", bus.req_ready); end
    tick();
    bus.resp_ack = '0;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL hold_after_ack_ready got %b exp 10", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    checks++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== 16'h000F)
      begin errors++; $display("FAIL hold_req1_resp got valid=%b data=%h exp 10/000f", bus.resp_valid, bus.resp_data); end
    bus.resp_ack = 2'b10;
    tick();
    bus.resp_ack = '0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    Reset_al       = 1'b0;
    bus.req_valid  = '0;
    bus.req_sr1    = '0;
    bus.req_sr2    = '0;
    bus.req_sext   = '0;
    bus.req_aluk   = '0;
    bus.req_sr2mux = '0;
    bus.resp_ack   = '0;
    test_reset();
    test_alu_ops();
    test_passa();
    test_arbitration();
    test_ack_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
